// File: rtl/xylo_pkg.sv
// xylo_pkg: note codes, seven-segment patterns and player state shared by the xylophone player
package xylo_pkg;

   localparam logic [2:0] NOTA_C     = 3'd0;
   localparam logic [2:0] NOTA_D     = 3'd1;
   localparam logic [2:0] NOTA_E     = 3'd2;
   localparam logic [2:0] NOTA_F     = 3'd3;
   localparam logic [2:0] NOTA_G     = 3'd4;
   localparam logic [2:0] NOTA_A     = 3'd5;
   localparam logic [2:0] NOTA_B     = 3'd6;
   localparam logic [2:0] NOTA_PAUSA = 3'd7;

   localparam logic [6:0] SEG_C     = 7'h4E;
   localparam logic [6:0] SEG_D     = 7'h3D;
   localparam logic [6:0] SEG_E     = 7'h4F;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_G     = 7'h5E;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1F;
   localparam logic [6:0] SEG_PAUSA = 7'h00;

   typedef enum logic {OCIOSO, TOCANDO} estado_t;

   // Letter shown on the display for a note code; a rest blanks it.
   function automatic logic [6:0] seg_of(input logic [2:0] n);
      return n == NOTA_C ? SEG_C :
             n == NOTA_D ? SEG_D :
             n == NOTA_E ? SEG_E :
             n == NOTA_F ? SEG_F :
             n == NOTA_G ? SEG_G :
             n == NOTA_A ? SEG_A :
             n == NOTA_B ? SEG_B : SEG_PAUSA;
   endfunction

endpackage

// File: rtl/xylo_fifo.sv
// xylo_fifo: synchronous note FIFO; pointers carry an extra bit so full and empty differ
module xylo_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   nivel,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_ok, pop_ok;

   assign nivel   = wr_q - rd_q;
   assign full    = nivel == (AW+1)'(DEPTH);
   assign empty   = wr_q == rd_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   // Advance each pointer by one on an accepted push or pop; a full FIFO refuses pushes even when popping.
   always_comb begin
      wr_d = push_ok ? wr_q + (AW+1)'(1) : wr_q;
      rd_d = pop_ok  ? rd_q + (AW+1)'(1) : rd_q;
   end

   // Pointer registers, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/xylo_player.sv
// xylo_player: buffered, timed note player driving the seven-segment letter, octave and status flags
module xylo_player
   import xylo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8,
   parameter int PRESC = 1000
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Valido,
   output logic                     Pronto,
   input  logic                     Tom,
   input  logic [2:0]               Notas,
   input  logic [DUR_W-1:0]         Duracao,
   input  logic                     Pausa,
   output logic [6:0]               Saidas,
   output logic                     Oitava,
   output logic                     Tocando,
   output logic                     Inicio,
   output logic [$clog2(DEPTH):0]   Nivel
);
   localparam int              PW   = PRESC > 1 ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0]   LAST = PW'(PRESC - 1);

   estado_t            state_q, state_d;
   logic [PW-1:0]      pres_q, pres_d;
   logic [DUR_W-1:0]   ticks_q, ticks_d;
   logic [6:0]         seg_q, seg_d;
   logic               oit_q, oit_d, toc_q, toc_d, ini_q, ini_d;

   logic [DUR_W+3:0]   f_dout;
   logic               f_full, f_empty;
   logic               wrap, tick_end, pop;
   logic               n_tom;
   logic [2:0]         n_nota;
   logic [DUR_W-1:0]   n_dur;

   xylo_fifo #(.DEPTH(DEPTH), .W(DUR_W + 4)) u_fifo (
      .clk   (Clock),
      .rst   (Reset),
      .push  (Valido),
      .pop   (pop),
      .din   ({Tom, Notas, Duracao}),
      .dout  (f_dout),
      .nivel (Nivel),
      .full  (f_full),
      .empty (f_empty)
   );

   assign {n_tom, n_nota, n_dur} = f_dout;
   assign wrap     = state_q == TOCANDO && !Pausa && pres_q == LAST;
   assign tick_end = wrap && ticks_q == DUR_W'(1);
   assign pop      = !f_empty && (state_q == OCIOSO || tick_end);

   assign Pronto  = !f_full;
   assign Saidas  = seg_q;
   assign Oitava  = oit_q;
   assign Tocando = toc_q;
   assign Inicio  = ini_q;

   // Next state: load a note on every pop, fall idle when the last tick ends with nothing queued,
   // otherwise run the prescaler and tick counter unless paused.
   always_comb begin
      state_d = state_q;
      pres_d  = pres_q;
      ticks_d = ticks_q;
      seg_d   = seg_q;
      oit_d   = oit_q;
      toc_d   = toc_q;
      ini_d   = 1'b0;
      if (pop) begin
         state_d = TOCANDO;
         pres_d  = '0;
         ticks_d = n_dur == '0 ? DUR_W'(1) : n_dur;
         seg_d   = seg_of(n_nota);
         oit_d   = n_tom;
         toc_d   = 1'b1;
         ini_d   = 1'b1;
      end else if (tick_end) begin
         state_d = OCIOSO;
         pres_d  = '0;
         ticks_d = '0;
         seg_d   = '0;
         oit_d   = 1'b0;
         toc_d   = 1'b0;
      end else if (state_q == TOCANDO && !Pausa) begin
         pres_d  = wrap ? '0 : pres_q + PW'(1);
         ticks_d = wrap ? ticks_q - DUR_W'(1) : ticks_q;
      end
   end

   // Player registers; reset returns everything to the silent idle state at once.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= OCIOSO;
         pres_q  <= '0;
         ticks_q <= '0;
         seg_q   <= '0;
         oit_q   <= 1'b0;
         toc_q   <= 1'b0;
         ini_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pres_q  <= pres_d;
         ticks_q <= ticks_d;
         seg_q   <= seg_d;
         oit_q   <= oit_d;
         toc_q   <= toc_d;
         ini_q   <= ini_d;
      end
   end

endmodule
